zwait_multi: RTL and testbench

// Synchronous, parametrised Z80 wait generator. Each of CHANNELS request sources can latch a pending wait.

---
 rtl/zwait_multi_if.sv | 25 ++
 rtl/zwait_multi.sv | 90 +++++++++
 tb/tb_zwait_multi.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/zwait_multi_if.sv
// Request/ack and status bundle between the Z80 wait generator and its requesters/AVR.
// The master side drives strobes and acks; the slave side (the wait generator) returns status.
interface zwait_multi_if #(
  parameter int CHANNELS = 7,
  parameter int CHAN_W   = 4
);
  logic [CHANNELS-1:0] wait_start;
  logic                wait_end;
  logic                tmo_ack;
  logic [CHANNELS-1:0] waits;
  logic [CHAN_W-1:0]   cur_chan;
  logic                spiint_n;
  logic                timeout;
  logic                tmo_flag;

  modport master (
    output wait_start, wait_end, tmo_ack,
    input  waits, cur_chan, spiint_n, timeout, tmo_flag
  );

  modport slave (
    input  wait_start, wait_end, tmo_ack,
    output waits, cur_chan, spiint_n, timeout, tmo_flag
  );
endinterface

// File: rtl/zwait_multi.sv
// Multi-channel Z80 /WAIT generator with lowest-index-first AVR service and a bus-release watchdog.
// Requests land one cycle after their rising edge; no backpressure, a held strobe simply counts once.
module zwait_multi #(
  parameter int CHANNELS = 7,
  parameter int CHAN_W   = 4,
  parameter int TMO_W    = 12,
  parameter int TMO_EN   = 1
) (
  input  logic  fclk,
  input  logic  rst,
  zwait_multi_if.slave bus,
  output wire   wait_n
);

  logic [CHANNELS-1:0] waits;
  logic [CHANNELS-1:0] wait_start_d;
  logic                wait_end_d;
  logic [CHANNELS-1:0] st_rise;
  logic                end_rise;
  logic [CHANNELS-1:0] clr;
  logic [CHANNELS-1:0] waits_next;
  logic [CHAN_W-1:0]   act;
  logic                any_wait;
  logic                fire;
  logic                timeout_q;
  logic                tmo_flag_q;

  assign st_rise  = bus.wait_start & ~wait_start_d;
  assign end_rise = bus.wait_end & ~wait_end_d;
  assign any_wait = |waits;

  // Scan downward so the last assignment is the lowest pending index.
  always_comb begin
    act = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (waits[i]) act = CHAN_W'(i);
    end
  end

  // Lowest set bit as a one-hot mask; the watchdog overrides the single-channel ack.
  always_comb begin
    clr = '0;
    if (end_rise) clr = waits & ~(waits - CHANNELS'(1));
    if (fire)     clr = '1;
    waits_next = (waits & ~clr) | st_rise;
  end

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      waits        <= '0;
      wait_start_d <= '0;
      wait_end_d   <= 1'b0;
      timeout_q    <= 1'b0;
      tmo_flag_q   <= 1'b0;
    end else begin
      waits        <= waits_next;
      wait_start_d <= bus.wait_start;
      wait_end_d   <= bus.wait_end;
      timeout_q    <= fire;
      if (fire)             tmo_flag_q <= 1'b1;
      else if (bus.tmo_ack) tmo_flag_q <= 1'b0;
    end
  end

  generate
    if (TMO_EN != 0) begin : g_wd
      logic [TMO_W-1:0] tmo_cnt;

      assign fire = any_wait & (tmo_cnt == '1);

      // Every ack restarts the window so each serviced channel gets the full timeout.
      always_ff @(posedge fclk or posedge rst) begin
        if (rst)                       tmo_cnt <= '0;
        else if (!any_wait)            tmo_cnt <= '0;
        else if (fire || end_rise)     tmo_cnt <= '0;
        else                           tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
    end else begin : g_no_wd
      assign fire = 1'b0;
    end
  endgenerate

  assign bus.waits    = waits;
  assign bus.cur_chan = act;
  assign bus.spiint_n = ~any_wait;
  assign bus.timeout  = timeout_q;
  assign bus.tmo_flag = tmo_flag_q;
  assign wait_n       = any_wait ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_zwait_multi.sv
// Directed bench for zwait_multi with a 4-bit watchdog so timeouts fire after 16 edges.
// The open-drain /WAIT line carries a pull-up, so a released line reads back as 1.
module tb_zwait_multi;
  localparam int CHANNELS = 7;
  localparam int CHAN_W   = 4;

  logic fclk = 1'b0;
  logic rst  = 1'b1;
  wire  wait_n;
  int   passed = 0;
  int   total  = 0;

  pullup (wait_n);

  zwait_multi_if #(.CHANNELS(CHANNELS), .CHAN_W(CHAN_W)) bus ();

  zwait_multi #(
    .CHANNELS(CHANNELS), .CHAN_W(CHAN_W), .TMO_W(4), .TMO_EN(1)
  ) dut (
    .fclk   (fclk),
    .rst    (rst),
    .bus    (bus.slave),
    .wait_n (wait_n)
  );

  always #5 fclk = ~fclk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge fclk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic [6:0] w, input logic [3:0] ch);
    check({tag, ".waits"}, 16'(bus.waits), 16'(w));
    check({tag, ".cur_chan"}, 16'(bus.cur_chan), 16'(ch));
    check({tag, ".wait_n"}, 16'(wait_n), (w != 0) ? 16'h0 : 16'h1);
    check({tag, ".spiint_n"}, 16'(bus.spiint_n), (w != 0) ? 16'h0 : 16'h1);
  endtask

  initial begin
    // Reset with every input asserted.
    bus.wait_start = 7'h7F;
    bus.wait_end   = 1'b1;
    bus.tmo_ack    = 1'b1;
    tick(3);
    check_status("reset", 7'h00, 4'd0);
    check("reset.tmo_flag", 16'(bus.tmo_flag), 16'h0);
    check("reset.timeout", 16'(bus.timeout), 16'h0);
    bus.wait_start = '0;
    bus.wait_end   = 1'b0;
    bus.tmo_ack    = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(5);
    check_status("idle", 7'h00, 4'd0);

    // Single channel set and ack.
    bus.wait_start = 7'h01;
    tick(1);
    bus.wait_start = 7'h00;
    check_status("single_set", 7'h01, 4'd0);
    bus.wait_end = 1'b1;
    tick(1);
    bus.wait_end = 1'b0;
    check_status("single_ack", 7'h00, 4'd0);
    tick(1);

    // Held strobe counts once, even after it is acked.
    bus.wait_start = 7'h01;
    tick(1);
    check_status("held_set", 7'h01, 4'd0);
    bus.wait_end = 1'b1;
    tick(1);
    bus.wait_end = 1'b0;
    tick(8);
    check_status("held_once", 7'h00, 4'd0);
    bus.wait_start = 7'h00;
    tick(1);

    // Ack with nothing pending.
    bus.wait_end = 1'b1;
    tick(1);
    bus.wait_end = 1'b0;
    check_status("idle_ack", 7'h00, 4'd0);
    tick(1);

    // Priority service.
    bus.wait_start = 7'h0A;
    tick(1);
    bus.wait_start = 7'h00;
    check_status("prio_set", 7'h0A, 4'd1);
    bus.wait_end = 1'b1;
    tick(1);
    bus.wait_end = 1'b0;
    check_status("prio_ack1", 7'h08, 4'd3);
    tick(1);
    check_status("prio_hold", 7'h08, 4'd3);
    bus.wait_end = 1'b1;
    tick(1);
    bus.wait_end = 1'b0;
    check_status("prio_ack2", 7'h00, 4'd0);
    tick(1);

    // Collision: set beats clear, and the watchdog window restarts.
    bus.wait_start = 7'h04;
    tick(1);
    bus.wait_start = 7'h00;
    tick(4);
    bus.wait_start = 7'h04;
    bus.wait_end   = 1'b1;
    tick(1);
    bus.wait_start = 7'h00;
    bus.wait_end   = 1'b0;
    check_status("collide", 7'h04, 4'd2);
    tick(15);
    check_status("collide_window", 7'h04, 4'd2);
    check("collide_no_tmo", 16'(bus.timeout), 16'h0);
    tick(1);
    check_status("collide_fire", 7'h00, 4'd0);
    check("collide_timeout", 16'(bus.timeout), 16'h1);
    bus.tmo_ack = 1'b1;
    tick(1);
    bus.tmo_ack = 1'b0;
    check("collide_ack_flag", 16'(bus.tmo_flag), 16'h0);

    // Watchdog on channel 5; a strobe and an ack coincide with the fire.
    bus.wait_start = 7'h20;
    tick(1);
    bus.wait_start = 7'h00;
    check_status("wd_set", 7'h20, 4'd5);
    tick(15);
    check_status("wd_window", 7'h20, 4'd5);
    check("wd_no_timeout", 16'(bus.timeout), 16'h0);
    check("wd_no_flag", 16'(bus.tmo_flag), 16'h0);
    bus.wait_start = 7'h04;
    bus.tmo_ack    = 1'b1;
    tick(1);
    bus.wait_start = 7'h00;
    bus.tmo_ack    = 1'b0;
    check_status("wd_fire", 7'h04, 4'd2);
    check("wd_timeout", 16'(bus.timeout), 16'h1);
    check("wd_flag_set_wins", 16'(bus.tmo_flag), 16'h1);
    tick(1);
    check("wd_pulse_end", 16'(bus.timeout), 16'h0);
    check("wd_flag_sticky", 16'(bus.tmo_flag), 16'h1);
    bus.tmo_ack = 1'b1;
    tick(1);
    bus.tmo_ack = 1'b0;
    check("wd_flag_clear", 16'(bus.tmo_flag), 16'h0);
    bus.wait_end = 1'b1;
    tick(1);
    bus.wait_end = 1'b0;
    check_status("wd_late_ack", 7'h00, 4'd0);
    tick(1);

    // Asynchronous reset between edges.
    bus.wait_start = 7'h41;
    tick(1);
    bus.wait_start = 7'h00;
    check_status("async_pre", 7'h41, 4'd0);
    #2;
    rst = 1'b1;
    #1;
    check_status("async_rst", 7'h00, 4'd0);
    tick(1);
    rst = 1'b0;
    tick(2);
    check_status("async_after", 7'h00, 4'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
